// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forwarding selects, sequencer state encoding and the NOP control word.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int TMO_W = 8;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding compare for one EX source operand.
// The EX/MEM result is newer than MEM/WB, so it wins a double match.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic [REG_AW-1:0] i_ex_rs,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_reg_write,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_reg_write,
  output logic [1:0]        o_fwd
);

  logic w_src_ok;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_src_ok  = !R0_ZERO || (i_ex_rs != '0);
  assign w_mem_hit = w_src_ok & i_mem_reg_write & (i_mem_rd == i_ex_rs);
  assign w_wb_hit  = w_src_ok & i_wb_reg_write & (i_wb_rd == i_ex_rs);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_mem_hit)
      o_fwd = FWD_MEM;
    else if (w_wb_hit)
      o_fwd = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, forwarding, memory freeze, branch flush.
// Define PIPE_HAZ_TIMEOUT_EN to add the MEM_WAIT timeout and mem_err pulse.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter bit R0_ZERO = 1'b1
`ifdef PIPE_HAZ_TIMEOUT_EN
  ,
  parameter int MEM_TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              branch_taken,
  output logic              stall_fe,
  output logic              bubble_ex,
  output logic              flush_fe,
  output logic              freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_err
);

  state_t r_state;
  logic   r_pend;

  logic       w_tmo;
  logic       w_freeze;
  logic       w_flush;
  logic       w_ex_load;
  logic       w_lu;
  logic       w_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

`ifdef PIPE_HAZ_TIMEOUT_EN
  logic [TMO_W-1:0] r_cnt;

  assign w_tmo = (r_state == ST_MEM_WAIT) & ~mem_ready
               & (r_cnt == TMO_W'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if ((r_state == ST_MEM_WAIT) & ~mem_ready & ~w_tmo)
      r_cnt <= r_cnt + 1'b1;
    else
      r_cnt <= '0;
  end
`else
  assign w_tmo = 1'b0;
`endif

  // A timed-out access releases the pipe even though memory never answered.
  assign w_freeze = mem_req & ~mem_ready & ~w_tmo;
  assign w_flush  = (branch_taken | r_pend) & ~w_freeze;

  assign w_ex_load = ex_mem_read & ex_reg_write
                   & (!R0_ZERO || (ex_rd != '0));
  assign w_lu = w_ex_load
              & ((id_rs1_used & (id_rs1 == ex_rd))
              |  (id_rs2_used & (id_rs2 == ex_rd)));
  assign w_stall = w_lu & ~w_freeze & ~w_flush;

  pipe_fwd_unit #(
    .REG_AW (REG_AW),
    .R0_ZERO(R0_ZERO)
  ) u_fwd_a (
    .i_ex_rs        (ex_rs1),
    .i_mem_rd       (mem_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .o_fwd          (w_fwd_a)
  );

  pipe_fwd_unit #(
    .REG_AW (REG_AW),
    .R0_ZERO(R0_ZERO)
  ) u_fwd_b (
    .i_ex_rs        (ex_rs2),
    .i_mem_rd       (mem_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .o_fwd          (w_fwd_b)
  );

  assign stall_fe  = ~rst & w_stall;
  assign bubble_ex = ~rst & w_stall;
  assign flush_fe  = ~rst & w_flush;
  assign freeze    = ~rst & w_freeze;
  assign fwd_a     = rst ? FWD_RF : w_fwd_a;
  assign fwd_b     = rst ? FWD_RF : w_fwd_b;
  assign mem_err   = ~rst & w_tmo;

  // EX is held while frozen, so a branch there is only seen once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pend  <= 1'b0;
    end else begin
      r_pend <= w_freeze & (r_pend | branch_taken);
      unique case (r_state)
        ST_RUN:
          if (w_freeze)
            r_state <= ST_MEM_WAIT;
        ST_MEM_WAIT:
          if (mem_ready | w_tmo)
            r_state <= ST_RUN;
      endcase
    end
  end

endmodule
